snake_head_ctl: RTL and testbench

SNAKE_HEAD_CTL -- requirements
Module: snake_head_ctl

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_step_timer.sv | 41 ++++
 rtl/snake_head_ctl.sv | 126 ++++++++++++
 tb/tb_snake_head_ctl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction codes, FSM encoding and cell geometry for the snake head
package snake_pkg;

   localparam logic [3:0] DIR_UP    = 4'b1000;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;

   localparam int CELL_W = 48;
   localparam int CELL_H = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   function automatic logic [3:0] dir_opposite(input logic [3:0] d);
      case (d)
         DIR_UP:    dir_opposite = DIR_DOWN;
         DIR_DOWN:  dir_opposite = DIR_UP;
         DIR_LEFT:  dir_opposite = DIR_RIGHT;
         DIR_RIGHT: dir_opposite = DIR_LEFT;
         default:   dir_opposite = 4'b0000;
      endcase
   endfunction

   function automatic logic dir_valid(input logic [3:0] d);
      dir_valid = (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
   endfunction

endpackage

// File: rtl/snake_step_timer.sv
// rtl/snake_step_timer.sv - vblank edge detect and frame counter raising step_due every N frames
module snake_step_timer #(
   parameter int FRAMES_PER_STEP = 8
) (
   input  logic pclk,
   input  logic rst,
   input  logic vblnk_in,
   input  logic clr,
   input  logic en,
   output logic step_due
);

   localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

   logic       vblnk_q, vblnk_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tick;

   always_comb begin
      tick     = vblnk_in & ~vblnk_q;
      vblnk_d  = vblnk_in;
      cnt_d    = cnt_q;
      step_due = en & tick & (cnt_q == LAST);
      if (clr) begin
         cnt_d = 8'd0;
      end else if (en && tick) begin
         cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vblnk_q <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         vblnk_q <= vblnk_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/snake_head_ctl.sv
// rtl/snake_head_ctl.sv - snake head position/direction controller stepping one cell per N frames
module snake_head_ctl
   import snake_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8,
   parameter int GRID_COLS       = 21,
   parameter int GRID_ROWS       = 12,
   parameter int START_COL       = 10,
   parameter int START_ROW       = 6
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vblnk_in,
   input  logic        start_in,
   input  logic        stop_in,
   input  logic [3:0]  dir_in,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic [3:0]  dir_out,
   output logic        running,
   output logic        step_pulse
);

   localparam logic [11:0] X_START = 12'(START_COL * CELL_W);
   localparam logic [11:0] Y_START = 12'(START_ROW * CELL_H);
   localparam logic [11:0] X_LAST  = 12'((GRID_COLS - 1) * CELL_W);
   localparam logic [11:0] Y_LAST  = 12'((GRID_ROWS - 1) * CELL_H);
   localparam logic [11:0] DX      = 12'(CELL_W);
   localparam logic [11:0] DY      = 12'(CELL_H);

   state_t      state_q, state_d;
   logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
   logic [3:0]  dir_q, dir_d, pend_q, pend_d;
   logic        running_q, running_d;
   logic        step_pulse_q, step_pulse_d;
   logic        step_due;

   snake_step_timer #(
      .FRAMES_PER_STEP(FRAMES_PER_STEP)
   ) u_timer (
      .pclk     (pclk),
      .rst      (rst),
      .vblnk_in (vblnk_in),
      .clr      (state_q == ST_IDLE),
      .en       (state_q == ST_WAIT),
      .step_due (step_due)
   );

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         xpos_q       <= X_START;
         ypos_q       <= Y_START;
         dir_q        <= DIR_RIGHT;
         pend_q       <= DIR_RIGHT;
         running_q    <= 1'b0;
         step_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         dir_q        <= dir_d;
         pend_q       <= pend_d;
         running_q    <= running_d;
         step_pulse_q <= step_pulse_d;
      end
   end

   // stop_in dominates everything, including a simultaneous start_in or a due step
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_in && !stop_in) state_d = ST_WAIT;
         ST_WAIT: begin
            if (stop_in)       state_d = ST_IDLE;
            else if (step_due) state_d = ST_STEP;
         end
         ST_STEP: state_d = stop_in ? ST_IDLE : ST_WAIT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      dir_d        = dir_q;
      pend_d       = pend_q;
      running_d    = (state_d != ST_IDLE);
      step_pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_in && !stop_in) begin
               xpos_d = X_START;
               ypos_d = Y_START;
               dir_d  = DIR_RIGHT;
               pend_d = DIR_RIGHT;
            end
         end
         ST_WAIT: begin
            // reversal is judged against the applied direction so two quick turns cannot fold back
            if (dir_valid(dir_in) && dir_in != dir_opposite(dir_q)) pend_d = dir_in;
         end
         ST_STEP: begin
            if (!stop_in) begin
               dir_d        = pend_q;
               step_pulse_d = 1'b1;
               case (pend_q)
                  DIR_UP:    ypos_d = (ypos_q == 12'd0)   ? Y_LAST : ypos_q - DY;
                  DIR_DOWN:  ypos_d = (ypos_q == Y_LAST)  ? 12'd0  : ypos_q + DY;
                  DIR_LEFT:  xpos_d = (xpos_q == 12'd0)   ? X_LAST : xpos_q - DX;
                  DIR_RIGHT: xpos_d = (xpos_q == X_LAST)  ? 12'd0  : xpos_q + DX;
                  default:   ;
               endcase
            end
         end
         default: ;
      endcase
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign dir_out    = dir_q;
   assign running    = running_q;
   assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_snake_head_ctl.sv
// tb/tb_snake_head_ctl.sv - scoreboard bench for snake_head_ctl against a cell-grid reference model
module tb_snake_head_ctl;

   localparam int F  = 8;
   localparam int GC = 21;
   localparam int GR = 12;
   localparam int SC = 10;
   localparam int SR = 6;
   localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010, RIGHT = 4'b0001;

   logic        pclk = 1'b0;
   logic        rst;
   logic        vblnk_in, start_in, stop_in;
   logic [3:0]  dir_in;
   logic [11:0] xpos, ypos;
   logic [3:0]  dir_out;
   logic        running, step_pulse;

   always #5 pclk = ~pclk;

   snake_head_ctl dut (
      .pclk       (pclk),
      .rst        (rst),
      .vblnk_in   (vblnk_in),
      .start_in   (start_in),
      .stop_in    (stop_in),
      .dir_in     (dir_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .dir_out    (dir_out),
      .running    (running),
      .step_pulse (step_pulse)
   );

   typedef struct { int x; int y; logic [3:0] d; } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   bit         m_run = 0, m_step = 0, m_vbp = 0;
   int         m_col = SC, m_row = SR, m_frames = 0;
   logic [3:0] m_dir = RIGHT, m_pend = RIGHT;

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   function automatic bit onehot4(input logic [3:0] d);
      return (d == UP) || (d == DOWN) || (d == LEFT) || (d == RIGHT);
   endfunction

   function automatic logic [3:0] opp(input logic [3:0] d);
      if (d == UP)   return DOWN;
      if (d == DOWN) return UP;
      if (d == LEFT) return RIGHT;
      return LEFT;
   endfunction

   function automatic void model_reset();
      m_run = 0; m_step = 0; m_vbp = 0; m_frames = 0;
      m_col = SC; m_row = SR; m_dir = RIGHT; m_pend = RIGHT;
      exp_q.delete();
   endfunction

   function automatic void model_cycle(input bit vb, input bit st, input bit sp, input logic [3:0] d);
      bit tick;
      tick  = vb && !m_vbp;
      m_vbp = vb;
      if (!m_run) begin
         if (st && !sp) begin
            m_run = 1; m_step = 0; m_frames = 0;
            m_col = SC; m_row = SR; m_dir = RIGHT; m_pend = RIGHT;
         end
      end else if (sp) begin
         m_run = 0; m_step = 0;
      end else if (m_step) begin
         m_dir = m_pend;
         if (m_dir == UP)    m_row = (m_row + GR - 1) % GR;
         if (m_dir == DOWN)  m_row = (m_row + 1) % GR;
         if (m_dir == LEFT)  m_col = (m_col + GC - 1) % GC;
         if (m_dir == RIGHT) m_col = (m_col + 1) % GC;
         exp_q.push_back('{m_col * 48, m_row * 64, m_dir});
         m_step = 0;
      end else begin
         if (onehot4(d) && d != opp(m_dir)) m_pend = d;
         if (tick) begin
            m_frames++;
            if (m_frames == F) begin
               m_frames = 0;
               m_step   = 1;
            end
         end
      end
   endfunction

   function automatic bit next_vb();
      return (cyc % 12) >= 9;
   endfunction

   function automatic bit due_now();
      return m_run && !m_step && (m_frames == F - 1) && next_vb() && !m_vbp;
   endfunction

   task automatic cyc1(input bit st, input bit sp, input logic [3:0] d);
      vblnk_in = next_vb();
      start_in = st;
      stop_in  = sp;
      dir_in   = d;
      @(posedge pclk);
      if (rst) model_reset();
      else     model_cycle(vblnk_in, st, sp, d);
      cyc++;
      #1;
   endtask

   task automatic wait_steps(input int n);
      int got = 0;
      for (int i = 0; i < 200 * n && got < n; i++) begin
         cyc1(0, 0, 4'b0000);
         if (step_pulse) got++;
      end
      check("wait_steps", got, n);
   endtask

   always @(negedge pclk) begin
      bit want;
      check("running", running, m_run);
      check("xpos", xpos, m_col * 48);
      check("ypos", ypos, m_row * 64);
      check("dir_out", dir_out, m_dir);
      want = (exp_q.size() != 0);
      check("step_pulse", step_pulse, want);
      if (want) begin
         mon_e = exp_q.pop_front();
         if (step_pulse) begin
            check("sb_xpos", xpos, mon_e.x);
            check("sb_ypos", ypos, mon_e.y);
            check("sb_dir", dir_out, mon_e.d);
         end
      end
   end

   initial begin
      rst = 1'b1; vblnk_in = 0; start_in = 0; stop_in = 0; dir_in = 0;
      repeat (3) cyc1(0, 0, 4'b0000);
      rst = 1'b0;
      check("rst_xpos", xpos, 480);
      check("rst_ypos", ypos, 384);
      check("rst_dir", dir_out, 1);
      check("rst_running", running, 0);
      repeat (30) cyc1(0, 0, 4'b0000);
      check("idle_no_run", running, 0);

      cyc1(1, 1, 4'b0000);
      check("start_stop_same", running, 0);

      cyc1(1, 0, 4'b0000);
      check("start_running", running, 1);
      wait_steps(1);
      check("first_step_x", xpos, 528);
      check("first_step_y", ypos, 384);

      wait_steps(9);
      check("col20_x", xpos, 960);
      wait_steps(1);
      check("wrap_right_x", xpos, 0);

      cyc1(0, 0, UP);
      wait_steps(1);
      check("up_y", ypos, 320);
      wait_steps(5);
      check("row0_y", ypos, 0);
      wait_steps(1);
      check("wrap_up_y", ypos, 704);

      cyc1(0, 0, RIGHT);
      wait_steps(1);
      check("right_again_x", xpos, 48);
      cyc1(0, 0, UP);
      cyc1(0, 0, LEFT);
      wait_steps(1);
      check("no_reversal_y", ypos, 640);
      check("no_reversal_dir", dir_out, UP);
      check("no_reversal_x", xpos, 48);

      cyc1(0, 0, RIGHT);
      wait_steps(1);
      cyc1(0, 0, 4'b0110);
      cyc1(0, 0, 4'b0000);
      cyc1(0, 0, 4'b1111);
      wait_steps(1);
      check("bad_dir_x", xpos, 144);
      check("bad_dir_dir", dir_out, RIGHT);

      for (int i = 0; i < 300 && !due_now(); i++) cyc1(0, 0, 4'b0000);
      cyc1(0, 1, 4'b0000);
      check("stop_at_due_run", running, 0);
      check("stop_at_due_x", xpos, 144);
      repeat (120) cyc1(0, 0, 4'b0000);
      cyc1(1, 0, 4'b0000);
      check("restart_x", xpos, 480);
      check("restart_y", ypos, 384);

      for (int i = 0; i < 300 && !due_now(); i++) cyc1(0, 0, 4'b0000);
      cyc1(0, 0, 4'b0000);
      cyc1(0, 1, 4'b0000);
      check("stop_in_step_x", xpos, 480);
      check("stop_in_step_run", running, 0);

      cyc1(1, 0, 4'b0000);
      for (int i = 0; i < 300 && !(m_run && !m_step && m_frames == 5); i++) cyc1(0, 0, DOWN);
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_x", xpos, 480);
      check("async_rst_y", ypos, 384);
      check("async_rst_dir", dir_out, 1);
      check("async_rst_run", running, 0);
      check("async_rst_pulse", step_pulse, 0);
      cyc1(0, 0, 4'b0000);
      cyc1(0, 0, 4'b0000);
      rst = 1'b0;
      repeat (200) cyc1(0, 0, 4'b0000);
      check("post_rst_idle", running, 0);

      for (int i = 0; i < 4000; i++) begin
         bit st, sp;
         logic [3:0] d;
         st = ($urandom % 40) == 0;
         sp = ($urandom % 500) == 0;
         d  = (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000;
         cyc1(st, sp, d);
      end
      repeat (4) cyc1(0, 1, 4'b0000);
      check("sb_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
